// File: rtl/uart_16550_pkg.sv
// rtl/uart_16550_pkg.sv - shared encodings and timing constants for the 16550 transmit path
package uart_16550_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int TICKS_PER_BIT = 16;

  // Stop-phase lengths in baud ticks: 1, 1.5 and 2 stop bits
  localparam logic [5:0] STOP_TICKS_1   = 6'd16;
  localparam logic [5:0] STOP_TICKS_1P5 = 6'd24;
  localparam logic [5:0] STOP_TICKS_2   = 6'd32;

endpackage

// File: rtl/uart_16550_tx_parity.sv
// rtl/uart_16550_tx_parity.sv - combinational parity bit for the active data bits of a frame
module uart_16550_tx_parity
  import uart_16550_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        word_len,
  input  logic              even_parity,
  input  logic              stick_parity,
  output logic              parity_bit
);

  logic [DATA_W-1:0] active;

  always_comb begin
    active     = data;
    parity_bit = 1'b0;
    case (word_len)
      WLEN_5:  active = data & DATA_W'(8'h1F);
      WLEN_6:  active = data & DATA_W'(8'h3F);
      WLEN_7:  active = data & DATA_W'(8'h7F);
      WLEN_8:  active = data & DATA_W'(8'hFF);
      default: active = data;
    endcase
    // Even parity makes the total count of ones even; stick forces the inverse of the even select
    if (stick_parity) parity_bit = ~even_parity;
    else              parity_bit = (^active) ^ ~even_parity;
  end

endmodule

// File: rtl/uart_16550_tx_serializer.sv
// rtl/uart_16550_tx_serializer.sv - pops Tx FIFO bytes and shifts out 16550 serial frames
module uart_16550_tx_serializer
  import uart_16550_pkg::*;
#(
  parameter int TICKS_PER_BIT = uart_16550_pkg::TICKS_PER_BIT,
  parameter int DATA_W        = 8
) (
  input  logic              WBs_CLK_i,
  input  logic              WBs_RST_i,
  input  logic              Baud_16x_Tick_i,
  input  logic [1:0]        Word_Len_i,
  input  logic              Stop_Bits_i,
  input  logic              Parity_En_i,
  input  logic              Even_Parity_i,
  input  logic              Stick_Parity_i,
  input  logic              Set_Break_i,
  input  logic              Tx_FIFO_Empty_i,
  input  logic [DATA_W-1:0] Tx_FIFO_DAT_i,
  output logic              Tx_FIFO_Pop_o,
  output logic              Tx_SOUT_o,
  output logic              Tx_Shift_Empty_o
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

  tx_state_e         state, state_d;
  logic [3:0]        tick_cnt, tick_d;
  logic [2:0]        bit_cnt, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        cfg_wlen, wlen_d;
  logic              cfg_par_en, par_en_d;
  logic              cfg_par_bit, par_bit_d;
  logic [5:0]        cfg_stop_len, stop_len_d;
  logic              sout_q, sout_d;
  logic              empty_q, empty_d;
  logic              load, bit_end, stop_done, load_parity, line_level;

  uart_16550_tx_parity #(.DATA_W(DATA_W)) u_parity (
    .data         (Tx_FIFO_DAT_i),
    .word_len     (Word_Len_i),
    .even_parity  (Even_Parity_i),
    .stick_parity (Stick_Parity_i),
    .parity_bit   (load_parity)
  );

  assign bit_end   = Baud_16x_Tick_i && (tick_cnt == TICK_LAST);
  // In STOP, bit_cnt counts whole stop bits so {bit_cnt, tick_cnt} is elapsed stop ticks
  assign stop_done = Baud_16x_Tick_i && (({bit_cnt[1:0], tick_cnt} + 6'd1) == cfg_stop_len);

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state        <= ST_IDLE;
      tick_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      shift_q      <= '0;
      cfg_wlen     <= WLEN_8;
      cfg_par_en   <= 1'b0;
      cfg_par_bit  <= 1'b0;
      cfg_stop_len <= STOP_TICKS_1;
      sout_q       <= 1'b1;
      empty_q      <= 1'b1;
    end else begin
      state        <= state_d;
      tick_cnt     <= tick_d;
      bit_cnt      <= bit_d;
      shift_q      <= shift_d;
      cfg_wlen     <= wlen_d;
      cfg_par_en   <= par_en_d;
      cfg_par_bit  <= par_bit_d;
      cfg_stop_len <= stop_len_d;
      sout_q       <= sout_d;
      empty_q      <= empty_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_d     = tick_cnt;
    bit_d      = bit_cnt;
    shift_d    = shift_q;
    wlen_d     = cfg_wlen;
    par_en_d   = cfg_par_en;
    par_bit_d  = cfg_par_bit;
    stop_len_d = cfg_stop_len;
    load       = 1'b0;
    line_level = 1'b1;

    if (Baud_16x_Tick_i && (state != ST_IDLE)) tick_d = bit_end ? 4'd0 : tick_cnt + 4'd1;

    case (state)
      ST_IDLE: load = ~Tx_FIFO_Empty_i;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt == (3'({1'b0, cfg_wlen}) + 3'd4)) begin
            bit_d   = 3'd0;
            state_d = cfg_par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (stop_done) begin
          bit_d  = 3'd0;
          tick_d = 4'd0;
          // Chain straight into the next frame when more data is waiting
          if (!Tx_FIFO_Empty_i) load = 1'b1;
          else                  state_d = ST_IDLE;
        end else if (bit_end) begin
          bit_d = bit_cnt + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d    = ST_START;
      tick_d     = 4'd0;
      bit_d      = 3'd0;
      shift_d    = Tx_FIFO_DAT_i;
      wlen_d     = Word_Len_i;
      par_en_d   = Parity_En_i;
      par_bit_d  = load_parity;
      stop_len_d = !Stop_Bits_i          ? STOP_TICKS_1 :
                   (Word_Len_i == WLEN_5) ? STOP_TICKS_1P5 : STOP_TICKS_2;
    end

    case (state_d)
      ST_START:  line_level = 1'b0;
      ST_DATA:   line_level = shift_d[0];
      ST_PARITY: line_level = par_bit_d;
      default:   line_level = 1'b1;
    endcase

    sout_d  = line_level & ~Set_Break_i;
    empty_d = (state_d == ST_IDLE);
  end

  // Gated by reset so a non-empty FIFO cannot see a pop while the block is held in reset
  assign Tx_FIFO_Pop_o    = load & ~WBs_RST_i;
  assign Tx_SOUT_o        = sout_q;
  assign Tx_Shift_Empty_o = empty_q;

endmodule

// File: tb/tb_uart_16550_tx_serializer.sv
// tb/tb_uart_16550_tx_serializer.sv - scoreboard bench for the 16550 transmit serializer
module tb_uart_16550_tx_serializer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] word_len;
  logic       stop_bits, par_en, even_par, stick_par, brk;
  logic       fifo_empty;
  logic [7:0] fifo_dat;
  logic       pop, sout, shift_empty;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic pop_seen = 1'b0;
  bit   mon_en = 1'b1;

  logic [7:0] fifo[$];
  logic [7:0] push_q[$];
  string      exp_pat[$];
  int         exp_stop[$];
  int         pop_cyc[$];

  uart_16550_tx_serializer dut (
    .WBs_CLK_i        (clk),
    .WBs_RST_i        (rst),
    .Baud_16x_Tick_i  (tick),
    .Word_Len_i       (word_len),
    .Stop_Bits_i      (stop_bits),
    .Parity_En_i      (par_en),
    .Even_Parity_i    (even_par),
    .Stick_Parity_i   (stick_par),
    .Set_Break_i      (brk),
    .Tx_FIFO_Empty_i  (fifo_empty),
    .Tx_FIFO_DAT_i    (fifo_dat),
    .Tx_FIFO_Pop_o    (pop),
    .Tx_SOUT_o        (sout),
    .Tx_Shift_Empty_o (shift_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input string pat, input int stop_cycles);
    exp_pat.push_back(pat);
    exp_stop.push_back(stop_cycles);
  endtask

  // FIFO model: head is visible combinationally, removed just after the edge that follows a pop
  initial begin : fifo_model
    fifo_empty = 1'b1;
    fifo_dat   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen && fifo.size() > 0) fifo.delete(0);
      while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
      fifo_empty = (fifo.size() == 0);
      fifo_dat   = fifo_empty ? 8'h00 : fifo[0];
    end
  end

  always @(negedge clk) begin
    pop_seen <= pop;
    if (pop) begin
      pop_cyc.push_back(cyc);
      check("pop_nonempty", int'(fifo_empty), 0);
    end
  end

  initial begin : frame_monitor
    string pat;
    int    stp, bad, n;
    bit    pending;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (mon_en && shift_empty === 1'b0 && sout === 1'b0) begin
        if (exp_pat.size() == 0) begin
          check("unexpected_frame", 1, 0);
          pat = "0";
          stp = 0;
        end else begin
          pat = exp_pat.pop_front();
          stp = exp_stop.pop_front();
        end
        for (int b = 0; b < pat.len(); b++) begin
          bad = 0;
          for (int c = 0; c < 16; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (sout !== (pat[b] == "1")) bad++;
          end
          check($sformatf("frame_%s_bit%0d_bad_cycles", pat, b), bad, 0);
        end
        n = 0;
        forever begin
          @(negedge clk);
          if (sout === 1'b1 && shift_empty === 1'b0 && n < 64) n++;
          else break;
        end
        check($sformatf("frame_%s_stop_cycles", pat), n, stp);
        pending = 1'b1;
      end
    end
  end

  task automatic set_cfg(input logic [1:0] wl, input logic sb, input logic pe,
                         input logic ev, input logic st);
    @(posedge clk);
    #1;
    word_len  = wl;
    stop_bits = sb;
    par_en    = pe;
    even_par  = ev;
    stick_par = st;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    push_q.push_back(b);
  endtask

  task automatic wait_done(output int end_cyc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (shift_empty !== 1'b0 && n < 20);
    check("frame_begins", int'(shift_empty === 1'b0), 1);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(shift_empty === 1'b1 && fifo_empty) && n < 3000);
    check("frame_ends", int'(shift_empty === 1'b1 && fifo_empty), 1);
    end_cyc = cyc;
  endtask

  task automatic wait_pop(output int p);
    int n;
    n = 0;
    while (pop_cyc.size() == 0 && n < 50) begin @(negedge clk); n++; end
    check("pop_seen", int'(pop_cyc.size() > 0), 1);
    p = (pop_cyc.size() > 0) ? pop_cyc[0] : cyc;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int e, p, bad;
    rst = 1'b1; tick = 1'b1; brk = 1'b0;
    word_len = 2'b11; stop_bits = 1'b0; par_en = 1'b0; even_par = 1'b0; stick_par = 1'b0;

    // Reset state with a byte already waiting: no pop may leak out while reset is held
    push_exp("010101010", 16);
    send(8'h55);
    repeat (3) @(negedge clk);
    check("reset_sout", int'(sout), 1);
    check("reset_pop", int'(pop), 0);
    check("reset_shift_empty", int'(shift_empty), 1);
    pop_cyc.delete();
    @(posedge clk); #1 rst = 1'b0;
    wait_done(e);
    check("8n1_pop_count", pop_cyc.size(), 1);
    check("8n1_pop_to_empty", e - pop_cyc[0], 161);

    // 7-bit word, parity variants on 0x41
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp("010000010", 16); send(8'h41); wait_done(e);
    set_cfg(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("010000011", 16); send(8'h41); wait_done(e);
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    push_exp("010000010", 16); send(8'h41); wait_done(e);
    set_cfg(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    push_exp("010000011", 16); send(8'h41); wait_done(e);

    // 5-bit word with even parity, upper bits of 0xF3 ignored, 1.5 stop bits
    set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp("0110011", 24); send(8'hF3); wait_done(e);

    // 6-bit word, 2 stop bits
    set_cfg(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("0010101", 32); send(8'h2A); wait_done(e);

    // Back-to-back frames
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("010100101", 16);
    push_exp("000111100", 16);
    pop_cyc.delete();
    @(posedge clk); #1;
    push_q.push_back(8'hA5);
    push_q.push_back(8'h3C);
    wait_done(e);
    check("b2b_pop_count", pop_cyc.size(), 2);
    check("b2b_pop_spacing", pop_cyc[1] - pop_cyc[0], 160);
    check("b2b_pop_to_empty", e - pop_cyc[0], 321);

    mon_en = 1'b0;

    // Break mid-DATA on an all-ones byte
    pop_cyc.delete();
    send(8'hFF);
    wait_pop(p);
    wait_until(p + 60);
    @(posedge clk); #1 brk = 1'b1;
    repeat (2) @(negedge clk);
    check("break_low", int'(sout), 0);
    bad = 0;
    repeat (15) begin @(negedge clk); if (sout !== 1'b0) bad++; end
    check("break_held_low", bad, 0);
    @(posedge clk); #1 brk = 1'b0;
    repeat (2) @(negedge clk);
    check("break_release", int'(sout), 1);
    wait_done(e);
    check("break_pop_to_empty", e - p, 161);

    // Baud tick stalled for 50 cycles during data bit 0 of 0x0F
    pop_cyc.delete();
    send(8'h0F);
    wait_pop(p);
    wait_until(p + 30);
    @(posedge clk); #1 tick = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (sout !== 1'b1) bad++; end
    @(posedge clk); #1 tick = 1'b1;
    check("tick_hold_level", bad, 0);
    wait_done(e);
    check("tick_hold_pop_to_empty", e - p, 211);

    // Reset during PARITY with another byte queued
    set_cfg(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    pop_cyc.delete();
    send(8'h41);
    wait_pop(p);
    wait_until(p + 5);
    send(8'h22);
    wait_until(p + 135);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_mid_sout", int'(sout), 1);
    check("rst_mid_pop", int'(pop), 0);
    check("rst_mid_shift_empty", int'(shift_empty), 1);
    bad = 0;
    repeat (5) begin @(negedge clk); if (pop !== 1'b0 || sout !== 1'b1) bad++; end
    check("rst_hold_quiet", bad, 0);
    pop_cyc.delete();
    @(posedge clk); #1 rst = 1'b0;
    wait_done(e);
    check("rst_release_pop_count", pop_cyc.size(), 1);
    check("rst_release_pop_to_empty", e - pop_cyc[0], 161);

    check("scoreboard_drained", exp_pat.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
